// File: rtl/fdc_read_sequencer_pkg.sv
// Shared encodings for the FDC read sequencer and address-mark decode.
// Latency: n/a (types, constants and a pure combinational helper).
// Backpressure: n/a.
package fdc_read_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HUNT = 2'd1,
        SYNC = 2'd2,
        DATA = 2'd3
    } state_t;

    // Raw MFM image of A1 with the missing clock bit
    localparam logic [15:0] SYNC_WORD_DEF = 16'h4489;

    // Data bits sit on the even raw positions, MSB at bit 14
    localparam int DATA_BIT_MSB  = 14;
    localparam int DATA_BIT_STEP = 2;

    // Strip the clock bits from a raw 16-bit MFM word
    function automatic logic [7:0] mfmDataByte(input logic [15:0] w);
        logic [7:0] b;
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            b[3'(7 - i)] = w[4'(DATA_BIT_MSB - DATA_BIT_STEP * i)];
        end
        return b;
    endfunction

endpackage

// File: rtl/fdc_read_sequencer_mfm_halfcell_shifter.sv
// Frames DPLL RCLK/RAWR into MFM half-cells and assembles 16-bit raw words.
// Latency: oWORD/oWORD_STB are combinational in the cycle the closing RCLK toggle is seen.
// Backpressure: none; the DPLL free-runs, every edge is consumed.
module mfm_halfcell_shifter (
    input  logic        iCLK,
    input  logic        iRESETn,
    input  logic        iRCLK,
    input  logic        iRAWR,
    input  logic        iCLEAR,
    input  logic        iALIGN,
    output logic [15:0] oWORD,
    output logic        oWORD_STB,
    output logic        oEDGE_STB
);

    logic        rRCLK_d;
    logic        rFlag;
    logic [15:0] rSHIFT;
    logic [3:0]  rHC;

    // A RAWR pulse that coincides with the toggle belongs to the window being closed
    assign oEDGE_STB = iRCLK ^ rRCLK_d;
    assign oWORD     = {rSHIFT[14:0], rFlag | iRAWR};
    assign oWORD_STB = oEDGE_STB && (rHC == 4'd15);

    // Delayed RCLK tracks continuously so a clear never manufactures an edge
    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            rRCLK_d <= 1'b0;
        end else begin
            rRCLK_d <= iRCLK;
        end
    end

    // Window flag, raw shift register and half-cell counter
    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            rFlag  <= 1'b0;
            rSHIFT <= 16'h0000;
            rHC    <= 4'd0;
        end else if (iCLEAR) begin
            rFlag  <= 1'b0;
            rSHIFT <= 16'h0000;
            rHC    <= 4'd0;
        end else if (oEDGE_STB) begin
            rFlag  <= 1'b0;
            rSHIFT <= oWORD;
            rHC    <= iALIGN ? 4'd0 : rHC + 4'd1;
        end else if (iRAWR) begin
            rFlag  <= 1'b1;
        end
    end

endmodule

// File: rtl/fdc_read_sequencer.sv
// Read-session sequencer: VFO control, A1 sync hunt, mark and data byte strobes.
// Latency: byte strobe registered, one iCLK after the cycle holding the 16th edge.
// Backpressure: none; bytes are pushed to the CRC/byte logic as they complete.
module fdc_read_sequencer
    import fdc_read_sequencer_pkg::*;
#(
    parameter int          HUNT_TIMEOUT = 200000,
    parameter int          SYNC_MIN     = 3,
    parameter logic [15:0] SYNC_WORD    = SYNC_WORD_DEF
) (
    input  logic       iCLK,
    input  logic       iRESETn,
    input  logic       iRCLK,
    input  logic       iRAWR,
    input  logic       iRD_REQ,
    input  logic       iABORT,
    output logic       oVFOE,
    output logic [7:0] oDATA,
    output logic       oDATA_STB,
    output logic       oMARK,
    output logic       oSYNC,
    output logic       oBUSY,
    output logic       oTIMEOUT
);

    localparam int             TW    = $clog2(HUNT_TIMEOUT + 1);
    localparam logic [TW-1:0]  TLAST = TW'(HUNT_TIMEOUT - 1);

    state_t         state;
    state_t         nextState;
    logic [15:0]    word;
    logic           wordStb;
    logic           edgeStb;
    logic           align;
    logic           exitReq;
    logic           isSync;
    logic [1:0]     a1cnt;
    logic [1:0]     a1Next;
    logic [TW-1:0]  tcnt;
    logic [TW-1:0]  tcntNext;
    logic           syncNext;
    logic           emit;
    logic           emitMark;
    logic           timeoutSet;

    mfm_halfcell_shifter u_shifter (
        .iCLK      (iCLK),
        .iRESETn   (iRESETn),
        .iRCLK     (iRCLK),
        .iRAWR     (iRAWR),
        .iCLEAR    (state == IDLE),
        .iALIGN    (align),
        .oWORD     (word),
        .oWORD_STB (wordStb),
        .oEDGE_STB (edgeStb)
    );

    assign exitReq = iABORT || !iRD_REQ;
    assign isSync  = edgeStb && (word == SYNC_WORD);

    // The PLL is released only while a session is live; it idles the same cycle IDLE is entered
    assign oVFOE = (state == IDLE);
    assign oBUSY = (state != IDLE);

    // Next-state and per-cycle actions; exits pre-empt any edge in the same cycle
    always_comb begin
        nextState  = state;
        a1Next     = a1cnt;
        tcntNext   = tcnt;
        syncNext   = oSYNC;
        emit       = 1'b0;
        emitMark   = 1'b0;
        align      = 1'b0;
        timeoutSet = 1'b0;
        case (state)
            IDLE: begin
                a1Next   = 2'd0;
                tcntNext = '0;
                syncNext = 1'b0;
                if (iRD_REQ && !iABORT) begin
                    nextState = HUNT;
                end
            end
            HUNT: begin
                if (exitReq) begin
                    nextState = IDLE;
                    syncNext  = 1'b0;
                end else if (oTIMEOUT) begin
                    // Pulse cycle: the session is abandoned whatever the DPLL shows
                    nextState = IDLE;
                end else if (isSync) begin
                    nextState = SYNC;
                    align     = 1'b1;
                    a1Next    = 2'd1;
                    syncNext  = 1'b1;
                end else if (tcnt == TLAST) begin
                    timeoutSet = 1'b1;
                end else begin
                    tcntNext = tcnt + 1'b1;
                end
            end
            SYNC: begin
                if (exitReq) begin
                    nextState = IDLE;
                    syncNext  = 1'b0;
                end else if (wordStb) begin
                    if (word == SYNC_WORD) begin
                        a1Next = (a1cnt == 2'd3) ? 2'd3 : a1cnt + 2'd1;
                    end else if (int'(a1cnt) >= SYNC_MIN) begin
                        emit      = 1'b1;
                        emitMark  = 1'b1;
                        nextState = DATA;
                    end else begin
                        nextState = HUNT;
                        syncNext  = 1'b0;
                        tcntNext  = '0;
                    end
                end
            end
            DATA: begin
                if (exitReq) begin
                    nextState = IDLE;
                    syncNext  = 1'b0;
                end else if (wordStb) begin
                    emit = 1'b1;
                end
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // State, sync-run count and hunt timer
    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            state <= IDLE;
            a1cnt <= 2'd0;
            tcnt  <= '0;
        end else begin
            state <= nextState;
            a1cnt <= a1Next;
            tcnt  <= tcntNext;
        end
    end

    // Registered outputs; oDATA holds its last byte between strobes
    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            oDATA     <= 8'h00;
            oDATA_STB <= 1'b0;
            oMARK     <= 1'b0;
            oSYNC     <= 1'b0;
            oTIMEOUT  <= 1'b0;
        end else begin
            oDATA_STB <= emit;
            oMARK     <= emitMark;
            oSYNC     <= syncNext;
            oTIMEOUT  <= timeoutSet;
            if (emit) begin
                oDATA <= mfmDataByte(word);
            end
        end
    end

endmodule

// File: tb/tb_fdc_read_sequencer.sv
// Directed bench for fdc_read_sequencer with a short hunt timeout.
// Latency: expects byte strobes the cycle after the closing half-cell edge.
// Backpressure: n/a.
module tb_fdc_read_sequencer;

    logic       iCLK;
    logic       iRESETn;
    logic       iRCLK;
    logic       iRAWR;
    logic       iRD_REQ;
    logic       iABORT;
    logic       oVFOE;
    logic [7:0] oDATA;
    logic       oDATA_STB;
    logic       oMARK;
    logic       oSYNC;
    logic       oBUSY;
    logic       oTIMEOUT;

    int errors = 0;
    int checks = 0;

    fdc_read_sequencer #(.HUNT_TIMEOUT(100)) dut (
        .iCLK      (iCLK),
        .iRESETn   (iRESETn),
        .iRCLK     (iRCLK),
        .iRAWR     (iRAWR),
        .iRD_REQ   (iRD_REQ),
        .iABORT    (iABORT),
        .oVFOE     (oVFOE),
        .oDATA     (oDATA),
        .oDATA_STB (oDATA_STB),
        .oMARK     (oMARK),
        .oSYNC     (oSYNC),
        .oBUSY     (oBUSY),
        .oTIMEOUT  (oTIMEOUT)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are then settled and inputs may change
    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    // One half-cell: RAWR in its own cycle, or coincident with the closing toggle
    task automatic sendBit(input logic b, input bit coinc);
        if (coinc) begin
            iRAWR = 1'b0;
            tick();
            iRAWR = b;
            iRCLK = ~iRCLK;
            tick();
            iRAWR = 1'b0;
        end else begin
            iRAWR = b;
            tick();
            iRAWR = 1'b0;
            iRCLK = ~iRCLK;
            tick();
        end
    endtask

    task automatic sendWord(input logic [15:0] w, input bit coinc);
        for (int i = 15; i >= 0; i--) begin
            sendBit(w[i], coinc);
        end
    endtask

    initial begin
        iRESETn = 1'b0;
        iRCLK   = 1'b0;
        iRAWR   = 1'b0;
        iRD_REQ = 1'b0;
        iABORT  = 1'b0;
        tick();
        tick();
        check("rst_vfoe",    oVFOE,     1'b1);
        check("rst_busy",    oBUSY,     1'b0);
        check("rst_sync",    oSYNC,     1'b0);
        check("rst_data",    oDATA,     8'h00);
        check("rst_stb",     oDATA_STB, 1'b0);
        check("rst_timeout", oTIMEOUT,  1'b0);
        iRESETn = 1'b1;
        tick();

        // Hunt with a silent DPLL: pulse 100 clocks after HUNT entry, IDLE one later
        iRD_REQ = 1'b1;
        tick();
        check("to_busy_entry", oBUSY, 1'b1);
        check("to_vfoe_entry", oVFOE, 1'b0);
        repeat (99) tick();
        check("to_not_yet", oTIMEOUT, 1'b0);
        tick();
        check("to_pulse",      oTIMEOUT, 1'b1);
        check("to_pulse_busy", oBUSY,    1'b1);
        tick();
        check("to_pulse_end", oTIMEOUT, 1'b0);
        check("to_idle_busy", oBUSY,    1'b0);
        check("to_idle_vfoe", oVFOE,    1'b1);
        tick();
        check("to_rehunt", oBUSY, 1'b1);
        iRD_REQ = 1'b0;
        tick();
        check("rdreq_exit", oBUSY, 1'b0);

        // Normal read: three A1 then FE mark, then data bytes
        iRD_REQ = 1'b1;
        tick();
        check("rd_vfoe", oVFOE, 1'b0);
        sendWord(16'h4489, 1'b0);
        check("rd_sync_first", oSYNC, 1'b1);
        sendWord(16'h4489, 1'b0);
        check("rd_no_stb_a1_2", oDATA_STB, 1'b0);
        sendWord(16'h4489, 1'b0);
        check("rd_no_stb_a1_3", oDATA_STB, 1'b0);
        sendWord(16'h5554, 1'b0);
        check("rd_mark_stb",  oDATA_STB, 1'b1);
        check("rd_mark_data", oDATA,     8'hFE);
        check("rd_mark_flag", oMARK,     1'b1);
        tick();
        check("rd_stb_pulse", oDATA_STB, 1'b0);
        check("rd_data_hold", oDATA,     8'hFE);
        sendWord(16'h4A4A, 1'b0);
        check("rd_d1_stb",  oDATA_STB, 1'b1);
        check("rd_d1_data", oDATA,     8'h88);
        check("rd_d1_mark", oMARK,     1'b0);
        sendWord(16'h4489, 1'b0);
        check("rd_a1_in_data",   oDATA,     8'hA1);
        check("rd_a1_in_data_m", oMARK,     1'b0);
        check("rd_a1_sync_held", oSYNC,     1'b1);
        sendWord(16'h2A55, 1'b1);
        check("rd_coinc_stb",  oDATA_STB, 1'b1);
        check("rd_coinc_data", oDATA,     8'h0F);

        // Asynchronous reset mid-word, no clock edge in between
        for (int i = 15; i >= 8; i--) begin
            sendBit(1'b1, 1'b0);
        end
        iRESETn = 1'b0;
        #1;
        check("arst_vfoe", oVFOE,     1'b1);
        check("arst_busy", oBUSY,     1'b0);
        check("arst_sync", oSYNC,     1'b0);
        check("arst_data", oDATA,     8'h00);
        check("arst_stb",  oDATA_STB, 1'b0);
        check("arst_mark", oMARK,     1'b0);
        iRD_REQ = 1'b0;
        tick();
        iRESETn = 1'b1;
        tick();

        // Short sync run falls back to HUNT, then a full run is accepted
        iRD_REQ = 1'b1;
        tick();
        sendWord(16'h4489, 1'b0);
        sendWord(16'h4489, 1'b0);
        sendWord(16'h5554, 1'b0);
        check("short_no_stb", oDATA_STB, 1'b0);
        check("short_sync_lo", oSYNC,    1'b0);
        check("short_busy",    oBUSY,    1'b1);
        sendWord(16'h4489, 1'b0);
        check("short_resync", oSYNC, 1'b1);
        sendWord(16'h4489, 1'b0);
        sendWord(16'h4489, 1'b0);
        sendWord(16'h5554, 1'b0);
        check("short_mark_stb",  oDATA_STB, 1'b1);
        check("short_mark_data", oDATA,     8'hFE);
        check("short_mark_flag", oMARK,     1'b1);

        // Abort landing on the 16th edge of a data word
        for (int i = 15; i >= 1; i--) begin
            sendBit(i[3:0] == 4'd14 || i[3:0] == 4'd11 || i[3:0] == 4'd9 ||
                    i[3:0] == 4'd6 || i[3:0] == 4'd3 || i[3:0] == 4'd1, 1'b0);
        end
        iRAWR = 1'b0;
        tick();
        iRCLK  = ~iRCLK;
        iABORT = 1'b1;
        tick();
        check("abort_no_stb", oDATA_STB, 1'b0);
        check("abort_busy",   oBUSY,     1'b0);
        check("abort_vfoe",   oVFOE,     1'b1);
        check("abort_sync",   oSYNC,     1'b0);
        iABORT  = 1'b0;
        iRD_REQ = 1'b0;
        tick();
        check("abort_still_idle", oBUSY,     1'b0);
        check("abort_late_stb",   oDATA_STB, 1'b0);

        // Fresh session after abort: the discarded partial word does not leak in
        iRD_REQ = 1'b1;
        tick();
        sendWord(16'h4489, 1'b0);
        sendWord(16'h4489, 1'b0);
        sendWord(16'h4489, 1'b0);
        sendWord(16'h5554, 1'b0);
        check("fresh_mark_stb",  oDATA_STB, 1'b1);
        check("fresh_mark_data", oDATA,     8'hFE);
        iRD_REQ = 1'b0;
        tick();
        check("fresh_exit_busy", oBUSY, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fdc_read_sequencer.md
Name: fdc_read_sequencer

Overview:
- Controls the FDC read data separator (DPLL) during sector reads.
- Drives the separator's VFO enable and frames the separator's outputs (RCLK, RAWR) into MFM half-cells.
- Hunts for the A1 sync word (raw 16'h4489, missing clock) and emits the address-mark byte, then data bytes, to the WD1793 byte/CRC logic.
- Sits between the DPLL and the read-track/read-sector command FSM.

Parameters:
- HUNT_TIMEOUT, 200000: iCLK cycles allowed in HUNT before giving up.
- SYNC_MIN, 3: consecutive A1 words required before the mark byte is accepted (range 1..3).
- SYNC_WORD, 16'h4489: raw MFM pattern of the sync byte.

Ports:
- iCLK input 1: system clock, shared with the DPLL.
- iRESETn input 1: asynchronous, active-low reset.
- iRCLK input 1: DPLL recovered clock; each toggle closes one half-cell window.
- iRAWR input 1: DPLL raw-read pulse, one iCLK cycle wide.
- iRD_REQ input 1: level; read session active while high.
- iABORT input 1: one-cycle force-terminate request.
- oVFOE output 1: to DPLL iVFOE; 1 = PLL held idle, 0 = PLL tracking.
- oDATA output 8: decoded byte, valid while oDATA_STB=1.
- oDATA_STB output 1: one-cycle byte strobe.
- oMARK output 1: qualifies oDATA_STB; 1 = first byte after the sync run (address mark).
- oSYNC output 1: high from the first A1 seen through the end of the session.
- oBUSY output 1: high in any state except IDLE.
- oTIMEOUT output 1: one-cycle pulse when HUNT expires.

Behaviour:
- Reset (async, iRESETn=0): state=IDLE, oVFOE=1, oDATA=8'h00, oDATA_STB=0, oMARK=0, oSYNC=0, oBUSY=0, oTIMEOUT=0; shift register, counters and window flag cleared.
- Edge detect: rRCLK_d registers iRCLK; half-cell edge = iRCLK ^ rRCLK_d.
- Window flag: set by iRAWR. On an edge cycle, rSHIFT[15:0] <= {rSHIFT[14:0], flag | iRAWR} and the flag clears. iRAWR coincident with an edge belongs to the closing window.
- Half-cell counter hc[3:0] increments on each edge; wraps 15->0. hc==15 edge = word boundary.
- Byte extraction from the updated word: data bits are positions 14,12,10,8,6,4,2,0 (MSB first). Clock bits (odd positions) are ignored.
- IDLE: oVFOE=1. iRD_REQ=1 -> HUNT next cycle; clear rSHIFT, hc, timeout counter, a1cnt; oSYNC=0.
- HUNT: oVFOE=0. Updated rSHIFT==SYNC_WORD on an edge -> SYNC, hc forced to 0 (alignment), a1cnt=1, oSYNC=1.
  - Timeout counter counts every iCLK. Reaching HUNT_TIMEOUT-1 -> oTIMEOUT=1 for one cycle, then IDLE.
  - Sync detect and timeout in the same cycle: sync wins.
- SYNC: at each word boundary:
  - word==SYNC_WORD: a1cnt++ (saturates at 3).
  - else if a1cnt>=SYNC_MIN: emit byte with oMARK=1 -> DATA.
  - else: -> HUNT, oSYNC=0, timeout counter restarts.
- DATA: each word boundary emits a byte, oMARK=0. A1 patterns inside data are emitted as bytes with no resync. Stays until exit.
- Strobe latency: oDATA_STB/oDATA/oMARK are registered and visible the cycle after the iCLK cycle in which the 16th edge was detected. oDATA holds until the next strobe.
- Exit priority: iABORT > iRD_REQ=0 > all else. Either -> IDLE next cycle from any state; no strobe issued that cycle even if an edge coincides.
- oVFOE rises in the same cycle the state enters IDLE, so the DPLL clears RCLK. A partial byte is discarded.
- iRD_REQ reasserted while in IDLE after an exit starts a fresh HUNT. No state carries over.

Decomposition:
- Shared package/include holds: state encoding (IDLE=2'd0, HUNT=2'd1, SYNC=2'd2, DATA=2'd3), SYNC_WORD, and data-bit position constants. The address-mark decoder reuses them.
- One sub-module, mfm_halfcell_shifter, containing:
  - RCLK edge detect;
  - window flag;
  - rSHIFT and hc counter, with a sync-align input that zeroes hc;
  - outputs word[15:0], word_stb, edge_stb.
- The top level holds the FSM, a1cnt, timeout counter and output registers.

Test Plan:
- Reset: assert iRESETn=0 mid-DATA -> all outputs at reset values immediately; oVFOE=1.
- Normal read: iRD_REQ=1; bench drives 3x 4489 then raw 5554 (byte FE) then 4A4A... -> oVFOE=0, oSYNC=1; strobe1 oDATA=8'hFE with oMARK=1; following strobes oMARK=0 with decoded values.
- Short sync (SYNC_MIN=3): drive 2x 4489 then FE raw -> no strobe; back to HUNT (oSYNC=0). Then 3x 4489+FE -> mark strobe.
- Timeout (HUNT_TIMEOUT=100): no sync pattern -> oTIMEOUT pulse at cycle 100 after HUNT entry; oBUSY=0 and oVFOE=1 the following cycle.
- Abort coincident with the 16th edge of a data word -> no oDATA_STB; IDLE next cycle; oVFOE=1.
- RAWR pulse in the same cycle as an RCLK toggle -> bit lands in the closing half-cell; verify via the decoded byte value.
